// File: rtl/reg_exec_mem_pkg.sv
// Shared pipeline definitions for the execute/memory boundary register.
package reg_exec_mem_pkg;

    localparam int unsigned CTRL_W = 35;

    // All-zero control word is the pipeline NOP.
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // Interrupt vector codes presented on int_vector.
    localparam logic [1:0] VEC_NONE = 2'b00;
    localparam logic [1:0] INT1_VEC = 2'b01;
    localparam logic [1:0] INT2_VEC = 2'b10;

    // Interrupt sequencer states: each names the slot to be emitted at the
    // next accepted clock edge.
    typedef enum logic [1:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        VECTOR
    } seq_state_t;

    // Kind of slot the memory-stage register loads on the next edge.
    typedef enum logic [2:0] {
        SLOT_BUBBLE,
        SLOT_INSTR,
        SLOT_PUSH_HI,
        SLOT_PUSH_LO,
        SLOT_JUMP
    } slot_t;

    // int1 wins when both interrupt tags arrive together.
    function automatic logic [1:0] first_source(input logic int1, input logic int2);
        if (int1) begin
            return INT1_VEC;
        end else if (int2) begin
            return INT2_VEC;
        end
        return VEC_NONE;
    endfunction

endpackage

// File: rtl/reg_exec_mem_if.sv
// Execute -> memory stage bus, including handshake and interrupt signals.
interface reg_exec_mem_if;
    import reg_exec_mem_pkg::*;

    // Execute-side inputs
    logic [15:0]       alu_result;
    logic [15:0]       Rs_data_execute;
    logic [2:0]        Rd_execute;
    logic [CTRL_W-1:0] control_signals_execute;
    logic [2:0]        flags;
    logic [31:0]       pc_execute;
    logic              int1_execute;
    logic              int2_execute;
    logic              stall;
    logic              flush;

    // Memory-side outputs
    logic [15:0]       alu_result_mem;
    logic [15:0]       store_data_mem;
    logic [2:0]        Rd_mem;
    logic [CTRL_W-1:0] control_signals_mem;
    logic              valid_mem;
    logic              int_push;
    logic              int_busy;
    logic              int_jump;
    logic [1:0]        int_vector;

    // Pipeline register side
    modport slave (
        input  alu_result, Rs_data_execute, Rd_execute, control_signals_execute,
        input  flags, pc_execute, int1_execute, int2_execute, stall, flush,
        output alu_result_mem, store_data_mem, Rd_mem, control_signals_mem,
        output valid_mem, int_push, int_busy, int_jump, int_vector
    );

    // Driving (execute stage / environment) side
    modport master (
        output alu_result, Rs_data_execute, Rd_execute, control_signals_execute,
        output flags, pc_execute, int1_execute, int2_execute, stall, flush,
        input  alu_result_mem, store_data_mem, Rd_mem, control_signals_mem,
        input  valid_mem, int_push, int_busy, int_jump, int_vector
    );

endinterface

// File: rtl/reg_exec_mem_int_push_seq.sv
// Interrupt sequencer: decides which slot the memory-stage register loads
// next, and walks the PC push / vector fetch sequence for an interrupt.
module int_push_seq
    import reg_exec_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        int1,
    input  logic        int2,
    input  logic [31:0] pc,
    output slot_t       slot,
    output logic [15:0] push_word,
    output logic [1:0]  vector,
    output logic        busy
);

    seq_state_t  state_q, state_d;
    logic        pend_q, pend_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  src_q, src_d;

    // State, pending int2, latched return PC and serviced source; frozen on stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            pc_q    <= '0;
            src_q   <= VEC_NONE;
        end else if (!stall) begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pc_q    <= pc_d;
            src_q   <= src_d;
        end
    end

    // Next-state and slot selection.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        pc_d      = pc_q;
        src_d     = src_q;
        slot      = SLOT_BUBBLE;
        push_word = '0;
        vector    = VEC_NONE;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    slot = SLOT_BUBBLE;
                end else begin
                    slot = SLOT_INSTR;
                    if (int1 || int2) begin
                        state_d = PUSH_HI;
                        pc_d    = pc;
                        src_d   = first_source(int1, int2);
                        pend_d  = int1 && int2;
                    end
                end
            end
            PUSH_HI: begin
                slot      = SLOT_PUSH_HI;
                push_word = pc_q[31:16];
                state_d   = PUSH_LO;
            end
            PUSH_LO: begin
                slot      = SLOT_PUSH_LO;
                push_word = pc_q[15:0];
                state_d   = VECTOR;
            end
            VECTOR: begin
                slot   = SLOT_JUMP;
                vector = src_q;
                // A deferred int2 re-runs the push with the same latched PC.
                if (pend_q) begin
                    state_d = PUSH_HI;
                    src_d   = INT2_VEC;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/reg_exec_mem.sv
// Execute -> memory pipeline register with interrupt PC push sequencing.
module reg_exec_mem
    import reg_exec_mem_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    reg_exec_mem_if.slave  bus
);

    slot_t             slot;
    logic [15:0]       push_word;
    logic [1:0]        vector;
    logic              busy;

    logic [15:0]       alu_q;
    logic [15:0]       sd_q;
    logic [2:0]        rd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              valid_q;
    logic              push_q;
    logic              jump_q;
    logic [1:0]        vec_q;

    // The CCR travels with the instruction but the memory stage has no use for it.
    logic unused_flags;
    assign unused_flags = ^bus.flags;

    int_push_seq u_seq (
        .clk       (clk),
        .reset     (reset),
        .stall     (bus.stall),
        .flush     (bus.flush),
        .int1      (bus.int1_execute),
        .int2      (bus.int2_execute),
        .pc        (bus.pc_execute),
        .slot      (slot),
        .push_word (push_word),
        .vector    (vector),
        .busy      (busy)
    );

    // Memory-stage register: loads the slot chosen by the sequencer unless stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_q   <= '0;
            sd_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= CTRL_NOP;
            valid_q <= 1'b0;
            push_q  <= 1'b0;
            jump_q  <= 1'b0;
            vec_q   <= VEC_NONE;
        end else if (!bus.stall) begin
            alu_q   <= '0;
            sd_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= CTRL_NOP;
            valid_q <= 1'b0;
            push_q  <= 1'b0;
            jump_q  <= 1'b0;
            vec_q   <= VEC_NONE;
            case (slot)
                SLOT_INSTR: begin
                    alu_q   <= bus.alu_result;
                    sd_q    <= bus.Rs_data_execute;
                    rd_q    <= bus.Rd_execute;
                    ctrl_q  <= bus.control_signals_execute;
                    valid_q <= 1'b1;
                end
                SLOT_PUSH_HI, SLOT_PUSH_LO: begin
                    sd_q    <= push_word;
                    push_q  <= 1'b1;
                    valid_q <= 1'b1;
                end
                SLOT_JUMP: begin
                    jump_q  <= 1'b1;
                    vec_q   <= vector;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.alu_result_mem      = alu_q;
    assign bus.store_data_mem      = sd_q;
    assign bus.Rd_mem              = rd_q;
    assign bus.control_signals_mem = ctrl_q;
    assign bus.valid_mem           = valid_q;
    assign bus.int_push            = push_q;
    assign bus.int_jump            = jump_q;
    assign bus.int_vector          = vec_q;
    assign bus.int_busy            = busy;

endmodule

// File: tb/tb_reg_exec_mem.sv
// Testbench for reg_exec_mem: directed vector table plus randomized run
// against a slot-queue reference model.
module tb_reg_exec_mem;
    import reg_exec_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;

    reg_exec_mem_if bus();

    reg_exec_mem dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        stl;
        logic        fl;
        logic [15:0] alu;
        logic [15:0] rs;
        logic [2:0]  rd;
        logic [34:0] ctrl;
        logic        i1;
        logic        i2;
        logic [31:0] pc;
        logic [2:0]  flags;
    } in_t;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] sd;
        logic [2:0]  rd;
        logic [34:0] ctrl;
        logic        valid;
        logic        push;
        logic        jump;
        logic [1:0]  vec;
        logic        busy;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } row_t;

    int   checks   = 0;
    int   failures = 0;
    row_t tbl[$];

    // Reference model: current expected outputs plus queue of forced slots.
    out_t m;
    out_t q[$];

    function automatic in_t mi(bit rst, bit stl, bit fl, logic [15:0] alu, logic [15:0] rs,
                               logic [2:0] rd, logic [34:0] ctrl, bit i1, bit i2, logic [31:0] pc);
        in_t t;
        t.rst = rst; t.stl = stl; t.fl = fl;
        t.alu = alu; t.rs = rs; t.rd = rd; t.ctrl = ctrl;
        t.i1 = i1; t.i2 = i2; t.pc = pc;
        t.flags = 3'($urandom);
        return t;
    endfunction

    function automatic out_t oz();
        out_t o = '0;
        return o;
    endfunction

    function automatic out_t oi(logic [15:0] alu, logic [15:0] sd, logic [2:0] rd,
                                logic [34:0] ctrl, bit busy);
        out_t o = '0;
        o.alu = alu; o.sd = sd; o.rd = rd; o.ctrl = ctrl; o.valid = 1'b1; o.busy = busy;
        return o;
    endfunction

    function automatic out_t op(logic [15:0] word, bit busy);
        out_t o = '0;
        o.sd = word; o.push = 1'b1; o.valid = 1'b1; o.busy = busy;
        return o;
    endfunction

    function automatic out_t oj(logic [1:0] vec, bit busy);
        out_t o = '0;
        o.jump = 1'b1; o.vec = vec; o.busy = busy;
        return o;
    endfunction

    task automatic add(input in_t i, input out_t e);
        row_t r;
        r.in = i;
        r.exp = e;
        tbl.push_back(r);
    endtask

    task automatic drive(input in_t i);
        reset                       = i.rst;
        bus.stall                   = i.stl;
        bus.flush                   = i.fl;
        bus.alu_result              = i.alu;
        bus.Rs_data_execute         = i.rs;
        bus.Rd_execute              = i.rd;
        bus.control_signals_execute = i.ctrl;
        bus.int1_execute            = i.i1;
        bus.int2_execute            = i.i2;
        bus.pc_execute              = i.pc;
        bus.flags                   = i.flags;
    endtask

    function automatic out_t get_out();
        out_t o;
        o.alu   = bus.alu_result_mem;
        o.sd    = bus.store_data_mem;
        o.rd    = bus.Rd_mem;
        o.ctrl  = bus.control_signals_mem;
        o.valid = bus.valid_mem;
        o.push  = bus.int_push;
        o.jump  = bus.int_jump;
        o.vec   = bus.int_vector;
        o.busy  = bus.int_busy;
        return o;
    endfunction

    task automatic check(input string nm, input int idx, input out_t exp);
        out_t got;
        got = get_out();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got alu=%h sd=%h rd=%0d ctrl=%h v=%b push=%b jump=%b vec=%b busy=%b | expected alu=%h sd=%h rd=%0d ctrl=%h v=%b push=%b jump=%b vec=%b busy=%b",
                     nm, idx, got.alu, got.sd, got.rd, got.ctrl, got.valid, got.push, got.jump,
                     got.vec, got.busy, exp.alu, exp.sd, exp.rd, exp.ctrl, exp.valid, exp.push,
                     exp.jump, exp.vec, exp.busy);
        end
    endtask

    // Append the three slots of one interrupt service (hi word, lo word, jump).
    task automatic queue_service(input logic [31:0] pc, input logic [1:0] vec);
        out_t s;
        s = '0; s.sd = pc[31:16]; s.push = 1'b1; s.valid = 1'b1; q.push_back(s);
        s = '0; s.sd = pc[15:0];  s.push = 1'b1; s.valid = 1'b1; q.push_back(s);
        s = '0; s.jump = 1'b1; s.vec = vec; q.push_back(s);
    endtask

    task automatic model_step(input in_t i);
        if (!i.rst) begin
            m = '0;
            q.delete();
        end else if (!i.stl) begin
            if (q.size() != 0) begin
                m = q.pop_front();
            end else if (i.fl) begin
                m = '0;
            end else begin
                m = '0;
                m.alu = i.alu; m.sd = i.rs; m.rd = i.rd; m.ctrl = i.ctrl; m.valid = 1'b1;
                if (i.i1) queue_service(i.pc, 2'b01);
                if (i.i2) queue_service(i.pc, 2'b10);
            end
        end
        m.busy = (q.size() != 0);
    endtask

    initial begin
        in_t junk;
        junk = mi(1, 0, 0, 16'hFACE, 16'hCAFE, 3'd5, 35'h3F, 1, 0, 32'h0BAD_0BAD);
        reset = 1'b0;
        drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset, basic load, stall hold (with flush and int), flush bubble
        add(mi(0, 0, 0, 16'h5A5A, 16'hA5A5, 3'd2, 35'h1, 1, 1, 32'hFFFF_FFFF), oz());
        add(mi(0, 1, 1, 16'h5A5A, 16'hA5A5, 3'd2, 35'h1, 1, 0, 32'h0),          oz());
        add(mi(1, 0, 0, 16'h1234, 16'h5555, 3'd3, 35'h1, 0, 0, 32'h0),          oi(16'h1234, 16'h5555, 3'd3, 35'h1, 0));
        add(mi(1, 1, 0, 16'hAAAA, 16'hBBBB, 3'd7, 35'h2, 0, 0, 32'h0),          oi(16'h1234, 16'h5555, 3'd3, 35'h1, 0));
        add(mi(1, 1, 1, 16'hCCCC, 16'hDDDD, 3'd6, 35'h3, 0, 0, 32'h0),          oi(16'h1234, 16'h5555, 3'd3, 35'h1, 0));
        add(mi(1, 1, 0, 16'hEEEE, 16'hFFFF, 3'd5, 35'h4, 1, 0, 32'h1111_2222),  oi(16'h1234, 16'h5555, 3'd3, 35'h1, 0));
        add(mi(1, 0, 1, 16'h9999, 16'h8888, 3'd5, 35'h7, 0, 0, 32'h0),          oz());
        add(mi(1, 0, 0, 16'h0001, 16'h0002, 3'd6, 35'h4_0000_0000, 0, 0, 32'h0), oi(16'h0001, 16'h0002, 3'd6, 35'h4_0000_0000, 0));
        // int1 service with a mid-sequence stall and ignored flush
        add(mi(1, 0, 0, 16'h1111, 16'h2222, 3'd1, 35'h3, 1, 0, 32'hABCD_0010),  oi(16'h1111, 16'h2222, 3'd1, 35'h3, 1));
        add(mi(1, 0, 1, 16'hDEAD, 16'hBEEF, 3'd7, 35'h1F, 0, 1, 32'h0),         op(16'hABCD, 1));
        add(mi(1, 1, 0, 16'h0, 16'h0, 3'd0, 35'h0, 0, 0, 32'h0),                op(16'hABCD, 1));
        add(mi(1, 0, 1, 16'h3333, 16'h4444, 3'd2, 35'h9, 1, 1, 32'hFFFF_FFFF),  op(16'h0010, 1));
        add(mi(1, 0, 0, 16'h5555, 16'h6666, 3'd3, 35'h1, 0, 0, 32'h0),          oj(2'b01, 0));
        add(mi(1, 0, 0, 16'h4242, 16'h0000, 3'd2, 35'h5, 0, 0, 32'h0),          oi(16'h4242, 16'h0000, 3'd2, 35'h5, 0));
        // Simultaneous int1 + int2: two back-to-back services, same PC words
        add(mi(1, 0, 0, 16'h0001, 16'h0002, 3'd4, 35'h8, 1, 1, 32'h1357_9BDF),  oi(16'h0001, 16'h0002, 3'd4, 35'h8, 1));
        add(junk, op(16'h1357, 1));
        add(junk, op(16'h9BDF, 1));
        add(junk, oj(2'b01, 1));
        add(junk, op(16'h1357, 1));
        add(junk, op(16'h9BDF, 1));
        add(mi(1, 0, 1, 16'h0, 16'h0, 3'd0, 35'h0, 0, 0, 32'h0),                oj(2'b10, 0));
        // int2 alone, then reset (with stall) while the low word is pending
        add(mi(1, 0, 0, 16'h0007, 16'h0008, 3'd7, 35'h7_FFFF_FFFF, 0, 1, 32'h0000_FFFF), oi(16'h0007, 16'h0008, 3'd7, 35'h7_FFFF_FFFF, 1));
        add(junk, op(16'h0000, 1));
        add(mi(0, 1, 0, 16'h1, 16'h1, 3'd1, 35'h1, 1, 1, 32'h1), oz());
        add(mi(1, 0, 0, 16'h0, 16'h0, 3'd0, 35'h0, 0, 0, 32'h0), oi(16'h0, 16'h0, 3'd0, 35'h0, 0));
        add(mi(1, 0, 0, 16'hFFFF, 16'hFFFF, 3'd7, 35'h7_FFFF_FFFF, 0, 0, 32'h0), oi(16'hFFFF, 16'hFFFF, 3'd7, 35'h7_FFFF_FFFF, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in);
            @(posedge clk);
            #1;
            check("dir", i, tbl[i].exp);
        end

        // Randomized run against the reference model
        for (int n = 0; n < 400; n++) begin
            in_t r;
            r.rst   = (n == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            r.stl   = ($urandom_range(0, 4) == 0);
            r.fl    = ($urandom_range(0, 5) == 0);
            r.alu   = 16'($urandom);
            r.rs    = 16'($urandom);
            r.rd    = 3'($urandom);
            r.ctrl  = 35'({$urandom, $urandom});
            r.i1    = ($urandom_range(0, 7) == 0);
            r.i2    = ($urandom_range(0, 7) == 0);
            r.pc    = $urandom;
            r.flags = 3'($urandom);
            drive(r);
            @(posedge clk);
            model_step(r);
            #1;
            check("rnd", n, m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_exec_mem.md
REG_EXEC_MEM -- requirements
Module: reg_exec_mem

Interface
REQ-001 SHALL have ports: clk in 1, single clock; all state updates on posedge.
REQ-002 SHALL have ports: reset in 1, synchronous, active-low; sampled on posedge clk.
REQ-003 SHALL have ports: alu_result in 16, execute-stage result; Rs_data_execute in 16, store data; Rd_execute in 3, destination register.
REQ-004 SHALL have ports: control_signals_execute in 35, opaque control bus; all-zero encoding is NOP.
REQ-005 SHALL have ports: flags in 3, execute CCR; pc_execute in 32, return PC of the execute instruction.
REQ-006 SHALL have ports: int1_execute in 1, int2_execute in 1, interrupt tags carried with the execute instruction.
REQ-007 SHALL have ports: stall in 1, memory busy, hold all state; flush in 1, replace the incoming instruction with a bubble.
REQ-008 SHALL have ports: alu_result_mem out 16; store_data_mem out 16; Rd_mem out 3; control_signals_mem out 35; valid_mem out 1.
REQ-009 SHALL have ports: int_push out 1, current slot is an interrupt stack push; int_busy out 1, upstream freeze request.
REQ-010 SHALL have ports: int_jump out 1, one-cycle vector-fetch pulse; int_vector out 2, 01=int1, 10=int2.

Function
REQ-011 Latency SHALL be exactly one clk: inputs sampled on posedge N appear on outputs after posedge N, registered, no combinational input-to-output paths.
REQ-012 stall=1 SHALL hold every output, the FSM state and pending bits unchanged; stall overrides flush and interrupt capture.
REQ-013 flush=1 with stall=0 in IDLE SHALL load control_signals_mem=0, valid_mem=0, Rd_mem=0 and discard int tags; data fields are don't-care but SHALL load 0.
REQ-014 Normal advance (IDLE, no stall, no flush) SHALL load all fields from execute and set valid_mem=1.
REQ-015 FSM states SHALL be IDLE, PUSH_HI, PUSH_LO and VECTOR.
REQ-016 IDLE->PUSH_HI SHALL occur when an accepted instruction carries int1_execute or int2_execute; the instruction itself SHALL be latched normally that cycle, together with pc_execute.
REQ-017 In PUSH_HI, the outputs SHALL be store_data_mem=pc[31:16], int_push=1, valid_mem=1, control_signals_mem=0; next state SHALL be PUSH_LO.
REQ-018 In PUSH_LO, the outputs SHALL be store_data_mem=pc[15:0], int_push=1; next state SHALL be VECTOR.
REQ-019 In VECTOR, int_jump=1 for exactly one cycle and int_vector SHALL be the serviced source; next state SHALL be IDLE.
REQ-020 int_busy SHALL be 1 in PUSH_HI, PUSH_LO and VECTOR; execute inputs are ignored in those states.
REQ-021 If int1 and int2 are simultaneous, int1 SHALL be serviced first; int2 SHALL be held in a pending bit and serviced immediately after VECTOR (VECTOR->PUSH_HI, reusing the latched PC).
REQ-022 flush SHALL be ignored in PUSH_HI, PUSH_LO and VECTOR; the interrupt sequence is not cancellable except by reset.
REQ-023 A stall asserted mid-sequence SHALL freeze the sequence; on release it SHALL resume at the same state with the same data.

Reset
REQ-024 With reset=0 at posedge, all outputs SHALL be 0, FSM=IDLE, pending bits and the latched PC cleared; this applies mid-sequence too.
REQ-025 Reset SHALL take priority over stall and flush.
REQ-026 The first cycle after reset release SHALL present valid_mem=0 (bubble) until the first accepted instruction.

Structure
REQ-027 A shared pipeline package SHALL hold: the FSM state enum, CTRL_W=35, the NOP control constant, and the INT1/INT2 vector codes.
REQ-028 The interrupt sequencer (FSM, pending bit, latched PC) SHALL be one sub-module, int_push_seq; the datapath register SHALL stay in reg_exec_mem.

Verification
REQ-029 Scenario: alu_result=16'h1234, Rd=3, ctrl=35'h1 with no stall -> next cycle alu_result_mem=16'h1234, Rd_mem=3, valid_mem=1.
REQ-030 Scenario: stall=1 for 3 cycles while inputs change -> outputs remain at pre-stall values throughout; flush=1 simultaneous -> still held.
REQ-031 Scenario: flush=1, ctrl=35'h7 -> control_signals_mem=0, valid_mem=0, next cycle.
REQ-032 Scenario: int1_execute=1, pc=32'hABCD_0010 -> after capture, store_data_mem=16'hABCD then 16'h0010 with int_push=1, then int_jump=1 and int_vector=01; int_busy high for 3 cycles.
REQ-033 Scenario: int1 and int2 together -> int1 sequence, then int2 sequence with int_vector=10, identical PC words; reset=0 during PUSH_LO -> all outputs 0 next cycle, FSM=IDLE, no int_jump.
